out_channel_checker: RTL and testbench

Consumer at the far end of a test program's output channel. It accepts output words one at a time over a valid/ready handshake and buffers them in a small FIFO. Each word is compared in order against an expected-value table loaded before the run. When the program signals completion and the FIFO has drained, the block raises `finished` and `success`. It replaces hard-wired per-test `outMem[k] == v` success chains in the FPGA test harness.

---
 rtl/out_channel_checker_if.sv | 12 +
 rtl/out_channel_checker.sv | 131 +++++++++++++
 tb/tb_out_channel_checker.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/out_channel_checker_if.sv
// Output-channel handshake between a program under test and its checker.
// The program drives words (master); the checker accepts them (slave).
interface out_channel_checker_if #(
  parameter int MemoryElementWidth = 12
);
  logic                          outValid;
  logic [MemoryElementWidth-1:0] outData;
  logic                          outReady;

  modport master (output outValid, output outData, input outReady);
  modport slave  (input outValid, input outData, output outReady);
endinterface

// File: rtl/out_channel_checker.sv
// Output-channel checker: receives program output words through a small FIFO,
// compares them in order against a preloaded expected table, and reports
// finished/success once the program is done and the FIFO has drained.
module out_channel_checker #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 5,
  parameter int FifoDepth          = 4,
  localparam int IdxW              = (NOut > 1) ? $clog2(NOut) : 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          expWrite,
  input  logic [IdxW-1:0]               expIndex,
  input  logic [MemoryElementWidth-1:0] expData,
  input  logic                          start,
  out_channel_checker_if.slave          ch,
  input  logic                          hold,
  input  logic                          progDone,
  output logic                          finished,
  output logic                          success,
  output logic                          mismatch,
  output logic [15:0]                   received
);

  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = PtrW + 1;

  typedef enum logic [1:0] {LOAD, RUN, DRAIN, DONE} state_t;

  state_t                        state;
  logic [MemoryElementWidth-1:0] expTable [NOut];
  logic [MemoryElementWidth-1:0] fifoMem  [FifoDepth];
  logic [PtrW-1:0]               wrPtr, rdPtr;
  logic [CntW-1:0]               count;
  logic                          overflow;
  logic                          doneLatch;

  logic                          full, empty, push, pop;
  logic                          canLoad;
  logic [MemoryElementWidth-1:0] rdData;
  logic [IdxW-1:0]               cmpIdx;
  logic                          inRange;

  // Full/empty come from the registered count only, so a same-cycle pop
  // never frees a slot for a push and a same-cycle push never feeds a pop.
  assign full    = (count == CntW'(FifoDepth));
  assign empty   = (count == '0);
  assign ch.outReady = (state == RUN) && !full;
  assign push    = ch.outValid && ch.outReady;
  assign pop     = !empty && !hold && ((state == RUN) || (state == DRAIN));
  assign canLoad = (state == LOAD) || (state == DONE);
  assign rdData  = fifoMem[rdPtr];
  assign cmpIdx  = received[IdxW-1:0];
  assign inRange = (received < 16'(NOut));

  // Expected table: loaded between runs, deliberately kept across reset.
  always_ff @(posedge clock) begin
    if (expWrite && canLoad && (int'(expIndex) < NOut))
      expTable[expIndex] <= expData;
  end

  // FIFO storage; occupancy and pointers live with the control state.
  always_ff @(posedge clock) begin
    if (push) fifoMem[wrPtr] <= ch.outData;
  end

  // Control FSM, FIFO pointers, comparator and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= LOAD;
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      received  <= '0;
      mismatch  <= 1'b0;
      overflow  <= 1'b0;
      doneLatch <= 1'b0;
      finished  <= 1'b0;
      success   <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CntW'(push) - CntW'(pop);

      // Word k = received is checked against expTable[k]; words beyond the
      // table only flag overflow.
      if (pop) begin
        if (inRange) begin
          if (rdData != expTable[cmpIdx]) mismatch <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
        if (received != 16'hFFFF) received <= received + 16'd1;
      end

      case (state)
        LOAD, DONE: begin
          if (start) begin
            state     <= RUN;
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            received  <= '0;
            mismatch  <= 1'b0;
            overflow  <= 1'b0;
            doneLatch <= 1'b0;
            finished  <= 1'b0;
            success   <= 1'b0;
          end
        end
        RUN: begin
          if (progDone || doneLatch) begin
            doneLatch <= 1'b1;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          // No pop can happen on this edge (FIFO empty), so the result
          // registers already hold their final values.
          if (empty) begin
            state    <= DONE;
            finished <= 1'b1;
            success  <= !mismatch && !overflow && (received == 16'(NOut));
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_out_channel_checker.sv
// Directed bench for out_channel_checker: stimulus pushes expected run
// results into a queue, a monitor pops and compares on each finished rise.
module tb_out_channel_checker;
  localparam int W = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          expWrite = 1'b0;
  logic [2:0]    expIndex = '0;
  logic [W-1:0]  expData = '0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic          progDone = 1'b0;
  logic          finished, success, mismatch;
  logic [15:0]   received;

  out_channel_checker_if #(.MemoryElementWidth(W)) ch ();

  out_channel_checker #(.MemoryElementWidth(W), .NOut(5), .FifoDepth(4)) dut (
    .clock(clock), .reset(reset), .expWrite(expWrite), .expIndex(expIndex),
    .expData(expData), .start(start), .ch(ch), .hold(hold),
    .progDone(progDone), .finished(finished), .success(success),
    .mismatch(mismatch), .received(received)
  );

  always #5 clock = ~clock;

  typedef struct { logic s; logic m; int r; } res_t;
  res_t expq[$];

  int npass = 0;
  int ntotal = 0;
  logic [W-1:0] words[$];

  task automatic check(input string name, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic expect_run(input logic s, input logic m, input int r);
    res_t e;
    e.s = s; e.m = m; e.r = r;
    expq.push_back(e);
  endtask

  // Send every word in 'words', honouring outReady, bounded in cycles.
  task automatic stream();
    int idx = 0;
    int cyc = 0;
    logic rdy;
    while (idx < words.size() && cyc < 100) begin
      ch.outValid = 1'b1;
      ch.outData  = words[idx];
      rdy = ch.outReady;
      tick();
      if (rdy) idx++;
      cyc++;
    end
    ch.outValid = 1'b0;
    if (idx < words.size()) check("stream_timeout", idx, words.size());
  endtask

  task automatic done_and_wait();
    int cyc = 0;
    progDone = 1'b1; tick(); progDone = 1'b0;
    while (!finished && cyc < 50) begin tick(); cyc++; end
    if (!finished) check("finish_timeout", 0, 1);
    tick();
  endtask

  // Scoreboard monitor: one expected record per rising edge of finished.
  initial begin
    logic prev = 1'b0;
    res_t e;
    forever begin
      @(negedge clock);
      if (finished && !prev) begin
        if (expq.size() == 0) check("unexpected_finish", 1, 0);
        else begin
          e = expq.pop_front();
          check("success", int'(success), int'(e.s));
          check("mismatch", int'(mismatch), int'(e.m));
          check("received", int'(received), e.r);
        end
      end
      prev = finished;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] tbl [5] = '{12'd1, 12'd2, 12'd1, 12'd1, 12'd2};
    int idx, cyc;
    logic rdy;
    ch.outValid = 1'b0;
    ch.outData  = '0;

    // Reset values
    #1;
    check("rst_outReady", int'(ch.outReady), 0);
    check("rst_finished", int'(finished), 0);
    check("rst_success", int'(success), 0);
    check("rst_mismatch", int'(mismatch), 0);
    check("rst_received", int'(received), 0);
    tick(); reset = 1'b1; tick();

    // Load table {1,2,1,1,2}
    for (int i = 0; i < 5; i++) begin
      expWrite = 1'b1; expIndex = 3'(i); expData = tbl[i]; tick();
    end
    expWrite = 1'b0;
    check("load_outReady", int'(ch.outReady), 0);

    // Run 1: all correct
    pulse_start();
    check("start_outReady", int'(ch.outReady), 1);
    expect_run(1'b1, 1'b0, 5);
    words = '{12'd1, 12'd2, 12'd1, 12'd1, 12'd2};
    stream();
    done_and_wait();

    // Run 2: 4th word wrong
    pulse_start();
    check("restart_finished", int'(finished), 0);
    expect_run(1'b0, 1'b1, 5);
    words = '{12'd1, 12'd2, 12'd1, 12'd3, 12'd2};
    stream();
    check("mm_after4_received", int'(received), 4);
    check("mm_after4_flag", int'(mismatch), 1);
    done_and_wait();

    // Run 3: short by one word
    pulse_start();
    expect_run(1'b0, 1'b0, 4);
    words = '{12'd1, 12'd2, 12'd1, 12'd1};
    stream();
    done_and_wait();

    // Run 4: one extra word -> overflow
    pulse_start();
    expect_run(1'b0, 1'b0, 6);
    words = '{12'd1, 12'd2, 12'd1, 12'd1, 12'd2, 12'd7};
    stream();
    done_and_wait();

    // Run 5: back-pressure with hold
    pulse_start();
    expect_run(1'b1, 1'b0, 5);
    words = '{12'd1, 12'd2, 12'd1, 12'd1, 12'd2};
    hold = 1'b1;
    idx = 0; cyc = 0;
    while (idx < 4 && cyc < 20) begin
      ch.outValid = 1'b1; ch.outData = words[idx];
      rdy = ch.outReady; tick();
      if (rdy) idx++;
      cyc++;
    end
    check("bp_accepts", idx, 4);
    check("bp_full_outReady", int'(ch.outReady), 0);
    ch.outData = words[4];
    tick(); tick();
    check("bp_still_blocked", int'(ch.outReady), 0);
    check("bp_no_compare", int'(received), 0);
    hold = 1'b0; tick();
    check("bp_ready_after_pop", int'(ch.outReady), 1);
    check("bp_first_pop", int'(received), 1);
    tick();
    ch.outValid = 1'b0;
    tick();
    check("bp_one_per_cycle", int'(received), 3);
    done_and_wait();

    // Run 6: progDone with 3 words held in the FIFO
    pulse_start();
    expect_run(1'b1, 1'b0, 5);
    words = '{12'd1, 12'd2};
    stream();
    tick();
    hold = 1'b1;
    words = '{12'd1, 12'd1, 12'd2};
    stream();
    check("drain_pre_received", int'(received), 2);
    progDone = 1'b1; tick(); progDone = 1'b0;
    check("drain_outReady", int'(ch.outReady), 0);
    tick(); tick();
    check("drain_held_finished", int'(finished), 0);
    hold = 1'b0;
    ch.outValid = 1'b1; ch.outData = 12'd9;   // must be ignored in DRAIN
    tick(); tick(); tick();
    check("drain_after_3rd_pop", int'(finished), 0);
    tick();
    check("drain_one_later", int'(finished), 1);
    ch.outValid = 1'b0;
    tick();

    // Run 7: reset mid-stream, then a clean run with the retained table
    pulse_start();
    words = '{12'd1, 12'd2, 12'd1};
    stream();
    check("mid_received", int'(received), 2);
    reset = 1'b0;
    #2;
    check("mid_rst_outReady", int'(ch.outReady), 0);
    check("mid_rst_received", int'(received), 0);
    check("mid_rst_finished", int'(finished), 0);
    tick(); reset = 1'b1; tick();
    pulse_start();
    expect_run(1'b1, 1'b0, 5);
    words = '{12'd1, 12'd2, 12'd1, 12'd1, 12'd2};
    stream();
    done_and_wait();

    tick(); tick();
    check("scoreboard_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
